// File: rtl/alu_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmp_pkg
//  Description : Shared definitions for the sequential compare unit:
//                predicate mode codes, FSM state encoding, and helpers for
//                signedness and predicate evaluation.
//  Contents    : MODE_EQ..MODE_GTU  3-bit predicate select codes
//                state_t            IDLE / RUN / DONE
//                is_signed()        true for the signed predicates
//                pred_bit()         maps lt/eq/gt flags to the 0/1 result
//  Revision    : 1.0  initial release
// ============================================================================
package alu_cmp_pkg;

   localparam logic [2:0] MODE_EQ  = 3'b000;
   localparam logic [2:0] MODE_NE  = 3'b001;
   localparam logic [2:0] MODE_LT  = 3'b010;
   localparam logic [2:0] MODE_GE  = 3'b011;
   localparam logic [2:0] MODE_LTU = 3'b100;
   localparam logic [2:0] MODE_GEU = 3'b101;
   localparam logic [2:0] MODE_GT  = 3'b110;
   localparam logic [2:0] MODE_GTU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_signed(input logic [2:0] mode);
      return (mode == MODE_LT) || (mode == MODE_GE) || (mode == MODE_GT);
   endfunction

   // Signed and unsigned variants of a predicate share the same flag
   // mapping because signedness was already folded into the operands.
   function automatic logic pred_bit(input logic [2:0] mode,
                                     input logic       lt,
                                     input logic       eq,
                                     input logic       gt);
      logic r;
      case (mode)
         MODE_EQ:           r = eq;
         MODE_NE:           r = ~eq;
         MODE_LT, MODE_LTU: r = lt;
         MODE_GE, MODE_GEU: r = ~lt;
         default:           r = gt;
      endcase
      return r;
   endfunction

endpackage : alu_cmp_pkg
`default_nettype wire

// File: rtl/alu_cmp_slice.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmp_slice
//  Description : Combinational unsigned compare of one CHUNK-bit slice.
//  Ports       : a_i, b_i  [CHUNK-1:0]  slice operands
//                slt_o                  a_i <  b_i
//                seq_o                  a_i == b_i
//                sgt_o                  a_i >  b_i
//  Revision    : 1.0  initial release
// ============================================================================
module alu_cmp_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   output logic             slt_o,
   output logic             seq_o,
   output logic             sgt_o
);

   assign slt_o = (a_i <  b_i);
   assign seq_o = (a_i == b_i);
   assign sgt_o = (a_i >  b_i);

endmodule : alu_cmp_slice
`default_nettype wire

// File: rtl/alu_cmp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmp_seq
//  Description : Multi-cycle handshaked relational compare unit. Compares two
//                WIDTH-bit operands MSB-first one CHUNK-bit slice per cycle,
//                stopping at the first differing slice.
//  Ports       : clk          system clock, rising edge
//                rst_n        asynchronous active-low reset
//                in_valid_i   operands/mode valid
//                in_ready_o   unit can accept (IDLE only)
//                a_i, b_i     [WIDTH-1:0] operands
//                mode_i       [2:0] predicate select
//                out_valid_o  result valid, held until accepted
//                out_ready_i  consumer accepts result
//                y_o          [WIDTH-1:0] zero-extended 0/1 predicate result
//                lt_o/eq_o/gt_o  raw relational flags
//  Revision    : 1.0  initial release
// ============================================================================
module alu_cmp_seq
   import alu_cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       mode_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] y_o,
   output logic             lt_o,
   output logic             eq_o,
   output logic             gt_o
);

   localparam int NCH  = WIDTH / CHUNK;
   localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCH - 1);

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("alu_cmp_seq: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [2:0]        mode_q, mode_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              y_q, y_d;
   logic              lt_q, lt_d;
   logic              eq_q, eq_d;
   logic              gt_q, gt_d;

   logic [CHUNK-1:0]  slice_a;
   logic [CHUNK-1:0]  slice_b;
   logic              slt, seq, sgt;

   // A single slice comparator walks the latched operands via idx_q.
   assign slice_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
   assign slice_b = b_q[int'(idx_q) * CHUNK +: CHUNK];

   alu_cmp_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a_i   (slice_a),
      .b_i   (slice_b),
      .slt_o (slt),
      .seq_o (seq),
      .sgt_o (sgt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= '0;
         idx_q   <= '0;
         y_q     <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         y_q     <= y_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      y_d     = y_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               a_d    = a_i;
               b_d    = b_i;
               // Flipping the sign bit maps two's-complement order onto
               // unsigned order, so the slice walk stays purely unsigned.
               if (is_signed(mode_i)) begin
                  a_d[WIDTH-1] = ~a_i[WIDTH-1];
                  b_d[WIDTH-1] = ~b_i[WIDTH-1];
               end
               mode_d  = mode_i;
               idx_d   = IDX_TOP;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!seq) begin
               lt_d    = slt;
               eq_d    = 1'b0;
               gt_d    = sgt;
               y_d     = pred_bit(mode_q, slt, 1'b0, sgt);
               state_d = ST_DONE;
            end else if (idx_q == '0) begin
               lt_d    = 1'b0;
               eq_d    = 1'b1;
               gt_d    = 1'b0;
               y_d     = pred_bit(mode_q, 1'b0, 1'b1, 1'b0);
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q - IDXW'(1);
            end
         end

         ST_DONE: begin
            if (out_ready_i) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Ready is masked by rst_n so the unit never advertises acceptance while
   // held in reset, even though the state register already reads IDLE.
   assign in_ready_o  = rst_n && (state_q == ST_IDLE);
   assign out_valid_o = (state_q == ST_DONE);
   assign lt_o        = lt_q;
   assign eq_o        = eq_q;
   assign gt_o        = gt_q;

   always_comb begin
      y_o    = '0;
      y_o[0] = y_q;
   end

endmodule : alu_cmp_seq
`default_nettype wire

// File: doc/alu_cmp_seq.md
Name: alu_cmp_seq

Overview:
Parametrised, handshaked successor to the team's 32-bit combinational greater-than comparator. Compares two WIDTH-bit operands MSB-first, one CHUNK-bit slice per cycle, and stops early at the first differing slice. Supports signed and unsigned modes and eight relational predicates. Returns a WIDTH-wide 0/1 result plus raw lt/eq/gt flags. Sits in the ALU datapath as the multi-cycle compare unit behind the issue handshake.

Parameters:
WIDTH, 32, operand and result width in bits
CHUNK, 8, bits compared per cycle; WIDTH % CHUNK must be 0, otherwise elaboration error
NCH, WIDTH/CHUNK, derived slice count; not overridable

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and mode valid
in_ready  out  1  unit can accept; high only in IDLE
a  in  WIDTH  operand A
b  in  WIDTH  operand B
mode  in  3  predicate select (see Behaviour)
out_valid  out  1  result valid; held until accepted
out_ready  in  1  consumer accepts result
y  out  WIDTH  predicate result, zero-extended: 1 = true, 0 = false
lt  out  1  A < B under the selected signedness
eq  out  1  A == B
gt  out  1  A > B under the selected signedness

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE; in_ready=1 after reset releases; out_valid=0, y=0, lt=0, eq=0, gt=0; latched operands and slice index are cleared.
- Mode encoding: 000 EQ, 001 NE, 010 LT, 011 GE, 100 LTU, 101 GEU, 110 GT, 111 GTU. Codes 010, 011, 110 are signed; all others are unsigned.
- Signed handling: on accept, bit WIDTH-1 of both operands is inverted before latching. Every later step is an unsigned compare.
- FSM:
  - IDLE: in_ready=1. On in_valid & in_ready, latch a, b and mode, set idx=NCH-1, go to RUN.
  - RUN: compare slice idx of A and B.
    - Slices differ: set lt/gt from that slice, eq=0, go to DONE.
    - Slices equal and idx==0: set eq=1, lt=0, gt=0, go to DONE.
    - Otherwise: idx decrements, stay in RUN.
  - DONE: out_valid=1. y, lt, eq and gt are registered and stable. On out_ready, go to IDLE and drop out_valid. No back-to-back accept in the same cycle.
- Latency from accept edge to out_valid:
  - Minimum 1 cycle (top slice differs).
  - Maximum NCH cycles (equal operands, or difference only in slice 0).
- Throughput: one operation per latency+1 cycles minimum.
- y is derived from the flags: EQ=eq, NE=!eq, LT/LTU=lt, GE/GEU=!lt, GT/GTU=gt.
- Output hold: outputs keep their values while out_valid=1 and out_ready=0. In IDLE, outputs hold the last result but out_valid=0.
- Input stability: in_valid asserted while in_ready=0 is ignored. a, b and mode may change freely after the accept edge.
- Reset mid-operation aborts: state=IDLE and all outputs return to reset values immediately.
- Boundaries:
  - a==b: eq=1 after exactly NCH cycles.
  - Signed: 0x80000000 vs 0x7FFFFFFF compares as less-than.
  - Unsigned: 0xFFFFFFFF vs 0 compares as greater-than.
  - CHUNK==WIDTH gives a fixed 1-cycle latency.

Decomposition:
- Package alu_cmp_pkg holds:
  - the 3-bit mode localparams (MODE_EQ … MODE_GTU)
  - the state encoding (IDLE, RUN, DONE)
  - a function is_signed(mode)
- Sub-module alu_cmp_slice: combinational CHUNK-bit unsigned compare producing slt/seq/sgt. It is instantiated once and indexed by idx.

Test Plan:
- WIDTH=32, CHUNK=8, mode=GTU, a=0x12000000, b=0x11FFFFFF -> out_valid 1 cycle after accept; y=1, gt=1, lt=0, eq=0.
- mode=EQ, a=b=0xDEADBEEF -> out_valid exactly 4 cycles after accept; y=1, eq=1. Then mode=NE on the same operands -> y=0.
- mode=LT (signed), a=0x80000000, b=0x7FFFFFFF -> y=1, lt=1. Then mode=LTU on the same operands -> y=0, gt=1.
- mode=GE, a=0x00000005, b=0x00000004 (difference only in slice 0) -> latency 4 cycles, y=1. Hold out_ready=0 for 5 cycles -> out_valid and y stable, in_ready=0, a new in_valid is ignored.
- Pulse rst_n low while in RUN with idx=2 -> out_valid=0, y=0 and in_ready=0 during reset. After release, in_ready=1; a fresh GT compare of 3 vs 2 gives y=1.
- Random regression: 10k random a, b and mode values with random out_ready back-pressure, checked against a reference model. Confirm latency always lies within 1..NCH and no accept occurs outside IDLE.
